// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-128 key schedule sequencer.
// Streams round keys 0..NUM_ROUNDS, sharing one external G word core.
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int G_TIMEOUT  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done,
  output logic         error,
  output logic         g_enable,
  output logic [31:0]  g_input,
  output logic [3:0]   g_round,
  input  logic [31:0]  g_output,
  input  logic         g_done
);

  typedef enum logic [2:0] {
    IDLE, EMIT, G_REQ, G_WAIT, FINISH
  } state_t;

  localparam int TW = $clog2(G_TIMEOUT + 1);
  localparam logic [3:0] RMAX = 4'(NUM_ROUNDS);
  localparam logic [TW-1:0] TLAST = TW'(G_TIMEOUT - 1);

  state_t        state, state_nx;
  logic [127:0]  cur_key, key_nx;
  logic [3:0]    round, round_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          err_q, err_nx;
  logic [31:0]   w0, w1, w2, w3;

  // Each new word chains off the previous new word.
  assign w0 = cur_key[127:96] ^ g_output;
  assign w1 = cur_key[95:64]  ^ w0;
  assign w2 = cur_key[63:32]  ^ w1;
  assign w3 = cur_key[31:0]   ^ w2;

  assign error = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_key <= '0;
      round   <= '0;
      tmo     <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_key <= key_nx;
      round   <= round_nx;
      tmo     <= tmo_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    key_nx   = cur_key;
    round_nx = round;
    tmo_nx   = tmo;
    err_nx   = err_q;
    busy     = 1'b1;
    rk_valid = 1'b0;
    rk_data  = '0;
    rk_index = '0;
    done     = 1'b0;
    g_enable = 1'b0;
    g_input  = '0;
    g_round  = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          key_nx   = key_in;
          round_nx = '0;
          err_nx   = 1'b0;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        rk_valid = 1'b1;
        rk_data  = cur_key;
        rk_index = round;
        if (rk_ready) begin
          if (round == RMAX) begin
            state_nx = FINISH;
          end else begin
            round_nx = round + 4'd1;
            state_nx = G_REQ;
          end
        end
      end
      G_REQ: begin
        g_enable = 1'b1;
        g_input  = cur_key[31:0];
        g_round  = round;
        tmo_nx   = '0;
        state_nx = G_WAIT;
      end
      G_WAIT: begin
        g_input = cur_key[31:0];
        g_round = round;
        if (g_done) begin
          key_nx   = {w0, w1, w2, w3};
          state_nx = EMIT;
        end else if (tmo == TLAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo + TW'(1);
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
